svfloat_pack_arbiter: RTL and testbench

//  Shares one combinational svfloat_packer among N_REQ requesters (e.g. add/mul/fma result stages).

---
 rtl/svfloat_pkg.sv | 19 +
 rtl/svfloat_packer.sv | 71 +++++++
 rtl/svfloat_rr_arbiter.sv | 33 +++
 rtl/svfloat_pack_arbiter.sv | 122 ++++++++++++
 tb/tb_svfloat_pack_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/svfloat_pkg.sv
// Shared float types and helpers for the svfloat packing path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package svfloat_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32_t;

    localparam int FLOAT32_EXPW = 8;

    // Index width that never collapses to zero bits, so a single requester still has an id.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svfloat_packer.sv
// Packs sign/unbiased exponent/mantissa plus override flags into an IEEE-style float.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module svfloat_packer #(
    parameter type float  = svfloat_pkg::float32_t,
    parameter int  ewidth = 9,
    parameter int  width  = 46,
    parameter int  frac   = 23,
    parameter int  expw   = svfloat_pkg::FLOAT32_EXPW
) (
    input  logic              inf,
    input  logic              nan,
    input  logic              zero,
    input  logic              sign,
    input  logic [ewidth-1:0] expo,
    input  logic [width-1:0]  man,
    output float              res
);

    localparam int FW   = $bits(float);
    localparam int MW   = FW - 1 - expw;
    localparam int BIAS = (1 << (expw - 1)) - 1;
    localparam int EMAX = (1 << expw) - 1;

    int                    lead;
    int                    e_b;
    int                    den_sh;
    logic [width-1:0]      norm;
    logic [width+MW-1:0]   ext;
    logic [MW-1:0]         frac_f;
    logic [MW-1:0]         den_f;
    logic [MW-1:0]         nan_m;
    logic [MW:0]           full;
    logic [MW:0]           den_full;
    logic [FW-1:0]         vec;

    always_comb begin
        lead = 0;
        for (int i = 0; i < width; i++) begin
            if (man[i]) lead = i;
        end
        // Biased exponent once the leading one is moved to the implicit-bit position.
        e_b      = int'($signed(expo)) + lead - frac + BIAS;
        norm     = man << (width - 1 - lead);
        ext      = {norm, {MW{1'b0}}};
        frac_f   = ext[width+MW-2 -: MW];
        full     = {1'b1, frac_f};
        den_sh   = 1 - e_b;
        den_full = (den_sh > MW) ? '0 : (full >> den_sh);
        den_f    = den_full[MW-1:0];
        nan_m    = '0;
        nan_m[MW-1] = 1'b1;

        vec = {sign, e_b[expw-1:0], frac_f};
        if (nan)
            vec = {1'b0, {expw{1'b1}}, nan_m};
        else if (inf)
            vec = {sign, {expw{1'b1}}, {MW{1'b0}}};
        else if (zero)
            vec = {sign, {expw{1'b0}}, {MW{1'b0}}};
        else if (e_b >= EMAX)
            vec = {sign, {expw{1'b1}}, {MW{1'b0}}};
        else if (man == '0)
            vec = {sign, {expw{1'b0}}, {MW{1'b0}}};
        else if (e_b <= 0)
            vec = {sign, {expw{1'b0}}, den_f};
    end

    assign res = vec;

endmodule

// File: rtl/svfloat_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own ready.
module svfloat_rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = svfloat_pkg::idx_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/svfloat_pack_arbiter.sv
// Shares one float packer among N_REQ requesters with round-robin grant and a tagged result.
// Latency: 2 cycles accept-to-result; one result per cycle sustained.
// Backpressure: res_ready stalls S2, then S1, then drops req_ready; nothing is lost or duplicated.
module svfloat_pack_arbiter
    import svfloat_pkg::*;
#(
    parameter type float  = float32_t,
    parameter int  ewidth = 9,
    parameter int  width  = 46,
    parameter int  frac   = 23,
    parameter int  N_REQ  = 4,
    localparam int IDW    = idx_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_inf,
    input  logic [N_REQ-1:0]        req_nan,
    input  logic [N_REQ-1:0]        req_zero,
    input  logic [N_REQ-1:0]        req_sign,
    input  logic [N_REQ*ewidth-1:0] req_exp,
    input  logic [N_REQ*width-1:0]  req_man,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output float                    res,
    output logic                    busy
);

    typedef struct packed {
        logic              inf;
        logic              nan;
        logic              zero;
        logic              sign;
        logic [ewidth-1:0] expo;
        logic [width-1:0]  man;
        logic [IDW-1:0]    id;
    } s1_t;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_ready;
    logic             s2_ready;
    logic             accept;
    s1_t              s1_q;
    s1_t              sel;
    float             pk_res;
    int               gi;

    svfloat_rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s2_ready  = !s2_valid || res_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign req_ready = (s1_ready && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign res_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;
    assign ptr_nxt   = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);

    always_comb begin
        sel      = '0;
        gi       = int'(grant_idx);
        sel.inf  = req_inf[gi];
        sel.nan  = req_nan[gi];
        sel.zero = req_zero[gi];
        sel.sign = req_sign[gi];
        sel.expo = req_exp[gi*ewidth +: ewidth];
        sel.man  = req_man[gi*width +: width];
        sel.id   = grant_idx;
    end

    svfloat_packer #(
        .float  (float),
        .ewidth (ewidth),
        .width  (width),
        .frac   (frac)
    ) u_packer (
        .inf  (s1_q.inf),
        .nan  (s1_q.nan),
        .zero (s1_q.zero),
        .sign (s1_q.sign),
        .expo (s1_q.expo),
        .man  (s1_q.man),
        .res  (pk_res)
    );

    // S1 and S2 advance independently so an accept and a drain can share a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            res      <= '0;
            res_id   <= '0;
            ptr      <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= accept;
                if (accept) s1_q <= sel;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    res    <= pk_res;
                    res_id <= s1_q.id;
                end
            end
            if (accept) ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_svfloat_pack_arbiter.sv
// Directed bench for svfloat_pack_arbiter: reset, latency, round-robin, stall, specials, mid-op reset.
// Requester i carries 2^i unless a step overrides it.
module tb_svfloat_pack_arbiter;

    logic                   clk;
    logic                   rst;
    logic [3:0]             req_valid;
    logic [3:0]             req_ready;
    logic [3:0]             req_inf;
    logic [3:0]             req_nan;
    logic [3:0]             req_zero;
    logic [3:0]             req_sign;
    logic [35:0]            req_exp;
    logic [183:0]           req_man;
    logic                   res_valid;
    logic                   res_ready;
    logic [1:0]             res_id;
    svfloat_pkg::float32_t  res;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    localparam logic [45:0] ONE = 46'h800000;

    logic [31:0] pow2 [4] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000};

    logic [8:0]  t_e   [6] = '{9'd0, 9'd200, 9'd0, 9'h17E, 9'd0, 9'd0};
    logic [45:0] t_m   [6] = '{ONE, ONE, 46'h0, ONE, 46'h1000000, 46'hC00000};
    logic        t_nan [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        t_sgn [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_exp [6] = '{32'h7FC00000, 32'h7F800000, 32'h80000000,
                               32'h00080000, 32'h40000000, 32'h3FC00000};

    svfloat_pack_arbiter #(
        .float  (svfloat_pkg::float32_t),
        .ewidth (9),
        .width  (46),
        .frac   (23),
        .N_REQ  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_inf   (req_inf),
        .req_nan   (req_nan),
        .req_zero  (req_zero),
        .req_sign  (req_sign),
        .req_exp   (req_exp),
        .req_man   (req_man),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res       (res),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic f_nan, input logic f_sign,
                           input logic [8:0] e, input logic [45:0] m);
        req_inf[i]          = 1'b0;
        req_nan[i]          = f_nan;
        req_zero[i]         = 1'b0;
        req_sign[i]         = f_sign;
        req_exp[i*9 +: 9]   = e;
        req_man[i*46 +: 46] = m;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] val, input logic [1:0] id);
        chk({tag, "_vld"}, 32'(res_valid), 32'd1);
        chk({tag, "_res"}, 32'(res), val);
        chk({tag, "_id"}, 32'(res_id), 32'(id));
    endtask

    initial begin
        rst       = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        req_inf   = '0;
        req_nan   = '0;
        req_zero  = '0;
        req_sign  = '0;
        req_exp   = '0;
        req_man   = '0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 9'(i), ONE);

        // Reset holds everything quiet even with all requests up.
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);

        // Single requester, two-cycle latency.
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("single_c1_vld", 32'(res_valid), 32'h0);
        chk("single_c1_busy", 32'(busy), 32'h1);
        tick();
        chk_res("single_c2", 32'h3F800000, 2'd0);
        tick();
        chk("single_done", 32'(res_valid), 32'h0);

        // Round-robin from a fresh pointer, all requesting.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = 4'b0000;
            #1;
            if (k < 8) chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k >= 2) chk_res($sformatf("rr_res%0d", k), pow2[(k-2) % 4], 2'((k-2) % 4));
            tick();
        end
        chk("rr_drained", 32'(res_valid), 32'h0);

        // Stall: only two entries fit, result held until release.
        res_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("stall_g0", 32'(req_ready), 32'b0001);
        tick();
        chk("stall_g1", 32'(req_ready), 32'b0010);
        tick();
        chk("stall_full_a", 32'(req_ready), 32'h0);
        chk_res("stall_hold_a", pow2[0], 2'd0);
        tick();
        chk("stall_full_b", 32'(req_ready), 32'h0);
        chk_res("stall_hold_b", pow2[0], 2'd0);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        tick();
        chk_res("stall_drain1", pow2[1], 2'd1);
        tick();
        chk("stall_empty_vld", 32'(res_valid), 32'h0);
        chk("stall_empty_busy", 32'(busy), 32'h0);

        // Special values streamed back-to-back through requester 2.
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                set_req(2, t_nan[k], t_sgn[k], t_e[k], t_m[k]);
                req_valid = 4'b0100;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (k < 6) chk($sformatf("spec_grant%0d", k), 32'(req_ready), 32'b0100);
            if (k >= 2) chk_res($sformatf("spec%0d", k - 2), t_exp[k-2], 2'd2);
            tick();
        end
        chk("spec_drained", 32'(res_valid), 32'h0);
        set_req(2, 1'b0, 1'b0, 9'd2, ONE);

        // Fill both stages, then reset mid-cycle.
        res_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("fill_g3", 32'(req_ready), 32'b1000);
        tick();
        chk("fill_g0", 32'(req_ready), 32'b0001);
        tick();
        chk("fill_busy", 32'(busy), 32'h1);
        chk_res("fill_hold", pow2[3], 2'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_vld", 32'(res_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_res", 32'(res), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("after_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        tick();
        req_valid = 4'b0000;
        chk_res("after_rst_r0", pow2[0], 2'd0);
        tick();
        chk_res("after_rst_r1", pow2[1], 2'd1);
        tick();
        chk("after_rst_done", 32'(res_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
